// File: rtl/fpu_pkg.sv
// Shared FPU definitions: the binary32 field layout and sign-related constants
// used by the sign-injection units.
package fpu_pkg;

  typedef struct packed {
    logic       sgn;
    logic [7:0] exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;
  localparam int unsigned FP32_SIGN_BIT = 31;

endpackage

// File: rtl/fsgnjx_core.sv
// Combinational sign-injection-XOR (FSGNJX.S / FABS.S when x1 == x2).
// Ports:
//   x1 - magnitude source, binary32
//   x2 - sign source, only bit 31 is consumed
//   y  - x1 with sign = sign(x1) ^ sign(x2); exponent and mantissa pass through
module fsgnjx_core
  import fpu_pkg::*;
(
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y
);

  fp32_t mag;
  fp32_t res;
  logic  unused_x2;

  // Only the raw sign bit of x2 matters, whatever its class (zero, NaN, Inf).
  assign unused_x2 = ^x2[30:0];

  always_comb begin
    mag     = fp32_t'(x1);
    res     = mag;
    res.sgn = mag.sgn ^ x2[FP32_SIGN_BIT];
  end

  assign y = res;

endmodule

// File: rtl/fsgnjx_unit.sv
// FSGNJX.S execute unit: sign-injection-XOR core followed by one output
// register with a valid/ready handshake on both sides.
// Ports:
//   clk       - clock, rising edge
//   rstn      - asynchronous active-low reset
//   in_valid  - x1/x2 carry an operand pair this cycle
//   in_ready  - unit can accept an operand pair
//   x1, x2    - operands (x2 supplies only its sign bit)
//   out_valid - y holds a result
//   out_ready - consumer takes y this cycle
//   y         - registered result
module fsgnjx_unit
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  logic [31:0] core_y;
  logic        accept;

  fsgnjx_core u_core (
    .x1 (x1),
    .x2 (x2),
    .y  (core_y)
  );

  // A retiring result frees the register in the same cycle a new one loads.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // y loads only on an accepted transfer so idle (possibly X) operands never reach it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      y         <= FP32_POS_ZERO;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= core_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fsgnjx_unit.sv
module tb_fsgnjx_unit;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int errors = 0;
  int checks = 0;

  fsgnjx_unit dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  // Reference: a negative x2 negates x1 (flip its sign), a positive x2 leaves it alone.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    if (b >= FP32_NEG_ZERO) model = a ^ FP32_NEG_ZERO;
    else                    model = a;
  endfunction

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x1 = 'x; x2 = 'x;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got=%h exp=00000000", y); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] t_x1 [6] = '{32'h3F80_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0001, 32'h0000_0001, 32'h7FC0_0001};
    logic [31:0] t_x2 [6] = '{32'h4000_0000, 32'hC000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFF80_0000};
    logic [31:0] t_y  [6] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h8000_0001, 32'h0000_0001, 32'hFFC0_0001};
    for (int i = 0; i < 6; i++) begin
      x1 = t_x1[i]; x2 = t_x2[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; x1 = 'x; x2 = 'x;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL directed_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (y !== t_y[i]) begin errors++; $display("FAIL directed_y[%0d] got=%h exp=%h", i, y, t_y[i]); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL directed_drop[%0d] got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] mans [7] = '{23'h0, 23'h1, 23'h2, 23'h38_0000, 23'h40_0000, 23'h3F_FFFF, 23'h7F_FFFF};
    logic [31:0] a, b, exp_y;
    logic [22:0] m1, m2;
    logic [7:0]  e1, e2;
    out_ready = 1'b1;
    for (int i = 0; i < 510; i++) begin
      if (i < 255) begin e1 = 8'(i); e2 = 8'($urandom_range(0, 254)); end
      else begin e1 = 8'($urandom_range(0, 254)); e2 = 8'(i - 255); end
      m1 = (i % 8 == 7) ? 23'($urandom) : mans[i % 8 % 7];
      m2 = ((i / 8) % 8 == 7) ? 23'($urandom) : mans[(i / 8) % 7];
      a = {1'($urandom), e1, m1};
      b = {1'($urandom), e2, m2};
      exp_y = model(a, b);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
      x1 = a; x2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || y !== exp_y) begin
        errors++; $display("FAIL b2b_y[%0d] x1=%h x2=%h got=%h/v%b exp=%h/v1", i, a, b, y, out_valid, exp_y);
      end
    end
    in_valid = 1'b0; x1 = 'x; x2 = 'x;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || ^y === 1'bx) begin
      errors++; $display("FAIL idle_after_stream out_valid=%b y=%h exp 0 and non-X", out_valid, y);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, exp_a, exp_c;
    a = 32'h4049_0FDB; exp_a = model(a, FP32_NEG_ZERO);
    x1 = a; x2 = FP32_NEG_ZERO; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; x1 = 32'h1234_5678; x2 = 32'h8765_4321;
    for (int i = 0; i < 3; i++) begin
      #0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || y !== exp_a) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h/v%b exp=%h/v1", i, y, out_valid, exp_a);
      end
    end
    // Retire the held result and load a new one on the same edge.
    exp_c = model(32'h1234_5678, 32'h8765_4321);
    out_ready = 1'b1;
    #0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL swap_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || y !== exp_c) begin
      errors++; $display("FAIL swap_y got=%h/v%b exp=%h/v1", y, out_valid, exp_c);
    end
    in_valid = 1'b0; x1 = 'x; x2 = 'x;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || y !== exp_c) begin
      errors++; $display("FAIL drain got=%h/v%b exp=%h/v0", y, out_valid, exp_c);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] exp_b;
    x1 = 32'hFF80_0000; x2 = 32'h7FC0_0000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; x1 = 'x; x2 = 'x;
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || y !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset got out_valid=%b y=%h in_ready=%b exp 0/00000000/1", out_valid, y, in_ready);
    end
    @(negedge clk); rstn = 1'b1;
    exp_b = model(32'h8000_0000, 32'h8000_0000);
    x1 = 32'h8000_0000; x2 = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; x1 = 'x; x2 = 'x;
    checks++; if (out_valid !== 1'b1 || y !== exp_b) begin
      errors++; $display("FAIL post_reset_accept got=%h/v%b exp=%h/v1", y, out_valid, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
